dn_benes_ctrl: RTL and testbench
================================

# dn_benes_ctrl

Sequencing controller that drives the Benes distribution network. It is the initiator side of the network's `set_en`/`route_en`/`route_signals` interface. It buffers incoming route configurations, loads each one into the routers while the network is empty, then streams data vectors through under a valid/ready handshake. It tracks in-flight vectors and applies downstream backpressure by holding `route_en` low. It sits between the sparse-operand fetch logic and the distribution network.

## Interface
- `N`, 32: network width in lanes (power of 2, ≥4).
- `DW_DATA`, 32: bits per lane.
- `N_LEVELS`, 2*$clog2(N)-1: router levels, which is also the network latency in advance cycles.
- `CFG_DEPTH`, 4: config FIFO depth (power of 2, ≥2).

Ports:
- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-high reset.
- `cfg_valid` in 1 / `cfg_ready` out 1 / `cfg_data` in N_LEVELS*N: route configuration push handshake.
- `in_valid` in 1 / `in_ready` out 1 / `in_data` in DW_DATA*N / `in_last` in 1: data vectors. `in_last` marks the final vector for the current config.
- `out_valid` out 1 / `out_ready` in 1 / `out_data` out DW_DATA*N: routed vectors.
- `dn_set_en` out 1, `dn_route_en` out 1, `dn_route_signals` out N_LEVELS*N, `dn_in` out DW_DATA*N: drive the network.
- `dn_out` in DW_DATA*N: network output.
- `busy` out 1: state ≠ IDLE or FIFO non-empty.
- `cfg_done` out 1: one-cycle pulse when a config's last vector has drained.

## Operation
- Config FIFO, CFG_DEPTH entries:
  - Push when `cfg_valid && cfg_ready`. `cfg_ready = !full`, with no same-cycle pop bypass.
  - Pop happens in LOAD.
  - `dn_route_signals` always shows the registered current config, captured at pop.
- Valid tracker: `vld[N_LEVELS-1:0]`.
  - `advance = !(out_valid && !out_ready)`.
  - When `advance`: `vld <= {vld[N_LEVELS-2:0], in_valid && in_ready}`.
  - `out_valid = vld[N_LEVELS-1]`, `out_data = dn_out`, `dn_in = in_data`.
- `dn_route_en = advance` in RUN and DRAIN, and 0 in IDLE and LOAD. Routers hold state while it is low, so a stall freezes the whole pipeline.
- `in_ready = (state==RUN) && advance`.
- FSM, with registered transitions:
  - IDLE: go to LOAD when the FIFO is non-empty.
  - LOAD: `dn_set_en=1` for exactly this cycle. Pop the head into the current-config register. Next state is RUN.
  - RUN: accept vectors. When a vector is accepted with `in_last=1`, go to DRAIN.
  - DRAIN: `in_ready=0`. On the first cycle with `vld==0`, pulse `cfg_done` and go to LOAD if the FIFO is non-empty, else IDLE.
- `dn_set_en` is never asserted while `vld != 0`, so a config is never changed under in-flight data.
- Config pushes are accepted in every state, including RUN and DRAIN, up to full.

## Timing
- Reset values:
  - state IDLE, FIFO empty, `vld=0`, current config 0.
  - `cfg_ready=1`.
  - `in_ready`, `out_valid`, `dn_set_en`, `dn_route_en`, `busy`, `cfg_done` all 0.
- Reset mid-stream: in-flight vectors are discarded and buffered configs are lost. No `cfg_done` pulse is produced.
- Config push at cycle t with FSM in IDLE: LOAD (`dn_set_en`) at t+1, RUN at t+2, first `in_ready` at t+2.
- Latency: a vector accepted at cycle t shows `out_valid` at t+N_LEVELS, given no stalls. Each stall cycle adds 1.
- Throughput: 1 vector/cycle in RUN with `out_ready=1`.
- Config turnaround: last vector accepted at t, with no stall and next config queued:
  - out at t+N_LEVELS;
  - `vld==0` seen at t+N_LEVELS+1 (`cfg_done` pulse);
  - LOAD at t+N_LEVELS+2, RUN at t+N_LEVELS+3.
- Backpressure: with `out_valid=1` and `out_ready=0`, `out_data`, `vld`, `dn_route_en=0` and `in_ready=0` all hold until `out_ready` rises.
- FIFO full: `cfg_ready=0` even in a LOAD (pop) cycle. It rises the cycle after the pop.
- `in_valid` outside RUN is ignored, since `in_ready=0`.

## Test plan
- Reset, then push one config C0 (N=8, DW_DATA=8, N_LEVELS=5) at cycle 1 -> `dn_set_en=1` at cycle 2 with `dn_route_signals=C0`, `in_ready=1` at cycle 3.
- Stream 4 vectors back-to-back, the last with `in_last`, `out_ready=1` -> `out_valid` for 4 consecutive cycles starting 5 cycles after the first accept; `cfg_done` pulses once; FSM returns to IDLE; `busy=0`.
- Queue C0 and C1; 2 vectors each -> no `dn_set_en` while `vld!=0`; C1 is loaded exactly 2 cycles after the last C0 vector exits; C1 vectors follow.
- Drop `out_ready` for 3 cycles while `out_valid=1` -> `out_data` is stable; `dn_route_en=0` and `in_ready=0` for those 3 cycles; no vector is lost or duplicated.
- Push 5 configs with CFG_DEPTH=4 while in RUN -> the 5th is held off with `cfg_ready=0` until the next LOAD pop + 1 cycle, then accepted; configs are applied in push order.
- Assert `reset` with 3 vectors in flight -> all outputs return to reset values immediately; no `out_valid` appears afterward.

Source files
------------

// File: rtl/dn_benes_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : dn_benes_ctrl
//  Description : Sequencing controller (initiator side) for the Benes
//                distribution network. Buffers route configurations in a
//                small FIFO, loads one into the routers while the network
//                is empty, then streams data vectors through with a
//                valid/ready handshake and in-flight tracking.
//  Ports       :
//    clk, reset              - clock, asynchronous active-high reset
//    cfg_valid/ready/data    - route configuration push handshake
//    in_valid/ready/data/last- input data vectors (last = end of config)
//    out_valid/ready/data    - routed output vectors
//    dn_set_en, dn_route_en  - router config load / pipeline advance
//    dn_route_signals, dn_in - config and data driven into the network
//    dn_out                  - network output data
//    busy                    - controller active or configs pending
//    cfg_done                - one-cycle pulse once a config has drained
//  Revision    : 1.0 - initial release
// ============================================================================
module dn_benes_ctrl #(
   parameter int N         = 32,
   parameter int DW_DATA   = 32,
   parameter int N_LEVELS  = 2*$clog2(N)-1,
   parameter int CFG_DEPTH = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    cfg_valid,
   output logic                    cfg_ready,
   input  logic [N_LEVELS*N-1:0]   cfg_data,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [DW_DATA*N-1:0]    in_data,
   input  logic                    in_last,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [DW_DATA*N-1:0]    out_data,
   output logic                    dn_set_en,
   output logic                    dn_route_en,
   output logic [N_LEVELS*N-1:0]   dn_route_signals,
   output logic [DW_DATA*N-1:0]    dn_in,
   input  logic [DW_DATA*N-1:0]    dn_out,
   output logic                    busy,
   output logic                    cfg_done
);

   localparam int CW = N_LEVELS * N;
   localparam int AW = $clog2(CFG_DEPTH);
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_LOAD  = 2'd1;
   localparam logic [1:0] ST_RUN   = 2'd2;
   localparam logic [1:0] ST_DRAIN = 2'd3;

   logic [1:0]          state_q, state_d;
   logic [CW-1:0]       fifo_mem_q [CFG_DEPTH];
   logic [AW:0]         wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]       cur_cfg_q;
   logic [N_LEVELS-1:0] vld_q;

   logic          w_empty;
   logic          w_full;
   logic          w_push;
   logic          w_pop;
   logic          w_have_cfg;
   logic          w_advance;
   logic          w_accept;
   logic          w_vld_empty;
   logic [CW-1:0] w_head;

   // ---------------------------------------------------------------------
   // Config FIFO (extra pointer bit distinguishes full from empty)
   // ---------------------------------------------------------------------
   assign w_empty    = (wr_ptr_q == rd_ptr_q);
   assign w_full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign cfg_ready  = !w_full;
   assign w_push     = cfg_valid && !w_full;
   // A config counts as available if one is stored or arrives this cycle;
   // this lets an IDLE push reach LOAD on the very next cycle.
   assign w_have_cfg = !w_empty || w_push;
   // Head of queue, bypassing the write when the FIFO is empty so the
   // current-config register can be loaded on the edge entering LOAD.
   assign w_head     = w_empty ? cfg_data : fifo_mem_q[rd_ptr_q[AW-1:0]];

   always_ff @(posedge clk) begin
      if (w_push) begin
         fifo_mem_q[wr_ptr_q[AW-1:0]] <= cfg_data;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (w_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
         if (w_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
   end

   // ---------------------------------------------------------------------
   // Current config: captured on the edge into LOAD so that the routers
   // see the new config in the same cycle dn_set_en is high. The FIFO
   // entry itself is retired (popped) during LOAD.
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cur_cfg_q <= '0;
      end else if (state_d == ST_LOAD) begin
         cur_cfg_q <= w_head;
      end
   end

   assign dn_route_signals = cur_cfg_q;

   // ---------------------------------------------------------------------
   // In-flight valid tracker; mirrors the router pipeline and freezes
   // with it whenever the output is stalled.
   // ---------------------------------------------------------------------
   assign out_valid   = vld_q[N_LEVELS-1];
   assign w_advance   = !(out_valid && !out_ready);
   assign w_accept    = in_valid && in_ready;
   assign w_vld_empty = (vld_q == '0);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vld_q <= '0;
      end else if (w_advance) begin
         vld_q <= {vld_q[N_LEVELS-2:0], w_accept};
      end
   end

   assign out_data = dn_out;
   assign dn_in    = in_data;
   assign busy     = (state_q != ST_IDLE) || !w_empty;

   // ---------------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------------------------------------------------------------
   // FSM: next state
   // ---------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (w_have_cfg) state_d = ST_LOAD;
         end
         ST_LOAD: begin
            state_d = ST_RUN;
         end
         ST_RUN: begin
            if (w_accept && in_last) state_d = ST_DRAIN;
         end
         ST_DRAIN: begin
            // Leave only once the network is empty, so a new config is
            // never loaded under in-flight data.
            if (w_vld_empty) state_d = w_have_cfg ? ST_LOAD : ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------
   // FSM: outputs
   // ---------------------------------------------------------------------
   always_comb begin
      dn_set_en   = 1'b0;
      dn_route_en = 1'b0;
      in_ready    = 1'b0;
      cfg_done    = 1'b0;
      w_pop       = 1'b0;
      case (state_q)
         ST_LOAD: begin
            dn_set_en = 1'b1;
            w_pop     = 1'b1;
         end
         ST_RUN: begin
            dn_route_en = w_advance;
            in_ready    = w_advance;
         end
         ST_DRAIN: begin
            dn_route_en = w_advance;
            cfg_done    = w_vld_empty;
         end
         default: begin
         end
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_dn_benes_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dn_benes_ctrl
//  Description : Directed self-checking bench for dn_benes_ctrl with a
//                behavioural network model (5-stage delay line that
//                advances on dn_route_en).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dn_benes_ctrl;

   localparam int N         = 8;
   localparam int DW_DATA   = 8;
   localparam int N_LEVELS  = 5;
   localparam int CFG_DEPTH = 4;
   localparam int CW        = N_LEVELS * N;
   localparam int DW        = DW_DATA * N;

   logic          clk;
   logic          reset;
   logic          cfg_valid;
   logic          cfg_ready;
   logic [CW-1:0] cfg_data;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_data;
   logic          in_last;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_data;
   logic          dn_set_en;
   logic          dn_route_en;
   logic [CW-1:0] dn_route_signals;
   logic [DW-1:0] dn_in;
   logic [DW-1:0] dn_out;
   logic          busy;
   logic          cfg_done;

   int total = 0;
   int bad   = 0;

   dn_benes_ctrl #(
      .N         (N),
      .DW_DATA   (DW_DATA),
      .N_LEVELS  (N_LEVELS),
      .CFG_DEPTH (CFG_DEPTH)
   ) u_dut (
      .clk              (clk),
      .reset            (reset),
      .cfg_valid        (cfg_valid),
      .cfg_ready        (cfg_ready),
      .cfg_data         (cfg_data),
      .in_valid         (in_valid),
      .in_ready         (in_ready),
      .in_data          (in_data),
      .in_last          (in_last),
      .out_valid        (out_valid),
      .out_ready        (out_ready),
      .out_data         (out_data),
      .dn_set_en        (dn_set_en),
      .dn_route_en      (dn_route_en),
      .dn_route_signals (dn_route_signals),
      .dn_in            (dn_in),
      .dn_out           (dn_out),
      .busy             (busy),
      .cfg_done         (cfg_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Network model: pure delay line that freezes when dn_route_en is low
   logic [DW-1:0] pipe_q [N_LEVELS];
   always @(posedge clk) begin
      if (dn_route_en) begin
         pipe_q[0] <= dn_in;
         for (int i = 1; i < N_LEVELS; i++) pipe_q[i] <= pipe_q[i-1];
      end
   end
   assign dn_out = pipe_q[N_LEVELS-1];

   // Collectors
   logic [DW-1:0] got_q [$];
   logic [DW-1:0] exp_q [$];
   logic [CW-1:0] cfg_log [$];
   int            n_done = 0;
   int            outstanding = 0;

   always @(posedge clk) begin
      if (reset) begin
         outstanding <= 0;
      end else begin
         if (out_valid && out_ready) got_q.push_back(out_data);
         if (dn_set_en) cfg_log.push_back(dn_route_signals);
         if (cfg_done) n_done <= n_done + 1;
         outstanding <= outstanding + ((in_valid && in_ready) ? 1 : 0)
                                    - ((out_valid && out_ready) ? 1 : 0);
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // A config must never be loaded while vectors are in flight
   always @(negedge clk) begin
      #1;
      if (!reset && dn_set_en) chk("set_en_while_inflight", 64'(outstanding), 64'd0);
   end

   logic [DW-1:0] v    [0:31];
   logic [CW-1:0] cfgv [0:10];   // 0=C0 1=CA 2=CB 3=CC 4=K0 5..9=K1..K5 10=R0

   task automatic wait_idle(input int max);
      for (int k = 0; k < max; k++) begin
         @(negedge clk); #1;
         if (!busy) break;
      end
      chk("wait_idle", 64'(busy), 64'd0);
   endtask

   task automatic send_last(input logic [DW-1:0] d, input int max);
      bit ok;
      ok = 1'b0;
      @(negedge clk);
      in_valid = 1'b1; in_data = d; in_last = 1'b1;
      for (int k = 0; k < max && !ok; k++) begin
         #1;
         if (in_ready) ok = 1'b1;
         else @(negedge clk);
      end
      @(negedge clk);
      in_valid = 1'b0; in_last = 1'b0;
      chk("send_accept", 64'(ok), 64'd1);
      exp_q.push_back(d);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 32; i++) v[i] = {32'hA5A5_0000 | 32'(i), 32'h0F0F_0000 + 32'(i * 3)};
      for (int i = 0; i < 11; i++) cfgv[i] = {8'(i + 1), 32'hC0FF_0000 + 32'(i * 7)};

      reset = 1'b1; cfg_valid = 1'b0; cfg_data = '0; in_valid = 1'b0;
      in_data = '0; in_last = 1'b0; out_ready = 1'b1;

      // ---------------- reset values ----------------
      repeat (2) @(negedge clk); #1;
      chk("rst_cfg_ready",   64'(cfg_ready),   64'd1);
      chk("rst_in_ready",    64'(in_ready),    64'd0);
      chk("rst_out_valid",   64'(out_valid),   64'd0);
      chk("rst_set_en",      64'(dn_set_en),   64'd0);
      chk("rst_route_en",    64'(dn_route_en), 64'd0);
      chk("rst_busy",        64'(busy),        64'd0);
      chk("rst_cfg_done",    64'(cfg_done),    64'd0);
      chk("rst_route_sig",   64'(dn_route_signals), 64'd0);

      @(negedge clk); reset = 1'b0;                       // cycle 0

      // ---------------- single config, 4 vectors ----------------
      @(negedge clk); cfg_valid = 1'b1; cfg_data = cfgv[0]; #1;   // cycle 1
      chk("t1_cfg_ready", 64'(cfg_ready), 64'd1);
      chk("t1_no_set_en", 64'(dn_set_en), 64'd0);
      @(negedge clk); cfg_valid = 1'b0; #1;                       // cycle 2
      chk("t1_set_en",    64'(dn_set_en), 64'd1);
      chk("t1_route_c0",  64'(dn_route_signals), 64'(cfgv[0]));
      chk("t1_load_nrdy", 64'(in_ready), 64'd0);
      for (int i = 0; i < 4; i++) begin                           // cycles 3..6
         @(negedge clk); in_valid = 1'b1; in_data = v[i]; in_last = (i == 3); #1;
         chk("t1_in_ready", 64'(in_ready), 64'd1);
         exp_q.push_back(v[i]);
      end
      chk("t1_route_en", 64'(dn_route_en), 64'd1);
      @(negedge clk); in_valid = 1'b0; in_last = 1'b0; #1;        // cycle 7
      chk("t1_drain_nrdy", 64'(in_ready), 64'd0);
      chk("t1_no_out_yet", 64'(out_valid), 64'd0);
      for (int i = 0; i < 4; i++) begin                           // cycles 8..11
         @(negedge clk); #1;
         chk("t1_out_valid", 64'(out_valid), 64'd1);
         chk("t1_out_data",  out_data, v[i]);
      end
      @(negedge clk); #1;                                         // cycle 12
      chk("t1_out_end",  64'(out_valid), 64'd0);
      chk("t1_cfg_done", 64'(cfg_done), 64'd1);
      @(negedge clk); #1;                                         // cycle 13
      chk("t1_done_once", 64'(cfg_done), 64'd0);
      chk("t1_idle",      64'(busy),     64'd0);

      // ---------------- two queued configs ----------------
      @(negedge clk); cfg_valid = 1'b1; cfg_data = cfgv[1]; #1;
      chk("t2_cfg_ready", 64'(cfg_ready), 64'd1);
      @(negedge clk); cfg_data = cfgv[2]; #1;
      chk("t2_set_en_a",  64'(dn_set_en), 64'd1);
      chk("t2_route_a",   64'(dn_route_signals), 64'(cfgv[1]));
      @(negedge clk); cfg_valid = 1'b0; in_valid = 1'b1; in_data = v[4]; #1;
      chk("t2_in_ready0", 64'(in_ready), 64'd1);
      exp_q.push_back(v[4]);
      @(negedge clk); in_data = v[5]; in_last = 1'b1; #1;
      chk("t2_in_ready1", 64'(in_ready), 64'd1);
      exp_q.push_back(v[5]);
      @(negedge clk); in_valid = 1'b0; in_last = 1'b0;
      repeat (2) @(negedge clk);
      @(negedge clk); #1;
      chk("t2_out0", out_data, v[4]);
      @(negedge clk); #1;
      chk("t2_out1", out_data, v[5]);
      @(negedge clk); #1;
      chk("t2_done_a",    64'(cfg_done),  64'd1);
      chk("t2_no_set_en", 64'(dn_set_en), 64'd0);
      @(negedge clk); #1;
      chk("t2_set_en_b",  64'(dn_set_en), 64'd1);
      chk("t2_route_b",   64'(dn_route_signals), 64'(cfgv[2]));
      chk("t2_empty_net", 64'(out_valid), 64'd0);
      @(negedge clk); in_valid = 1'b1; in_data = v[6]; #1;
      chk("t2_in_ready2", 64'(in_ready), 64'd1);
      exp_q.push_back(v[6]);
      @(negedge clk); in_data = v[7]; in_last = 1'b1; #1;
      exp_q.push_back(v[7]);
      @(negedge clk); in_valid = 1'b0; in_last = 1'b0;
      wait_idle(30);

      // ---------------- backpressure ----------------
      @(negedge clk); cfg_valid = 1'b1; cfg_data = cfgv[3];
      @(negedge clk); cfg_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk); in_valid = 1'b1; in_data = v[8 + i]; #1;
         chk("t3_in_ready", 64'(in_ready), 64'd1);
         exp_q.push_back(v[8 + i]);
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); in_data = v[13]; in_last = 1'b1; out_ready = 1'b0; #1;
         chk("t3_stall_valid", 64'(out_valid),   64'd1);
         chk("t3_stall_data",  out_data,         v[8]);
         chk("t3_stall_route", 64'(dn_route_en), 64'd0);
         chk("t3_stall_nrdy",  64'(in_ready),    64'd0);
      end
      @(negedge clk); out_ready = 1'b1; #1;
      chk("t3_resume_rdy",   64'(in_ready),    64'd1);
      chk("t3_resume_data",  out_data,         v[8]);
      chk("t3_resume_route", 64'(dn_route_en), 64'd1);
      exp_q.push_back(v[13]);
      @(negedge clk); in_valid = 1'b0; in_last = 1'b0;
      wait_idle(30);

      // ---------------- FIFO full ----------------
      @(negedge clk); cfg_valid = 1'b1; cfg_data = cfgv[4];
      @(negedge clk); cfg_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); cfg_valid = 1'b1; cfg_data = cfgv[5 + i]; #1;
         chk("t4_push_rdy", 64'(cfg_ready), 64'd1);
      end
      @(negedge clk); cfg_data = cfgv[9]; in_valid = 1'b1; in_data = v[14]; in_last = 1'b1; #1;
      chk("t4_full",     64'(cfg_ready), 64'd0);
      chk("t4_in_ready", 64'(in_ready),  64'd1);
      exp_q.push_back(v[14]);
      @(negedge clk); in_valid = 1'b0; in_last = 1'b0; #1;
      chk("t4_full_hold", 64'(cfg_ready), 64'd0);
      repeat (3) @(negedge clk);
      @(negedge clk); #1;
      chk("t4_out", out_data, v[14]);
      @(negedge clk); #1;
      chk("t4_done",      64'(cfg_done),  64'd1);
      chk("t4_full_done", 64'(cfg_ready), 64'd0);
      @(negedge clk); #1;
      chk("t4_load",      64'(dn_set_en), 64'd1);
      chk("t4_full_pop",  64'(cfg_ready), 64'd0);
      chk("t4_route_k1",  64'(dn_route_signals), 64'(cfgv[5]));
      @(negedge clk); #1;
      chk("t4_rdy_after_pop", 64'(cfg_ready), 64'd1);
      @(negedge clk); cfg_valid = 1'b0;
      for (int i = 0; i < 5; i++) send_last(v[15 + i], 30);
      wait_idle(40);

      // ---------------- reset with vectors in flight ----------------
      @(negedge clk); cfg_valid = 1'b1; cfg_data = cfgv[10];
      @(negedge clk); cfg_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); in_valid = 1'b1; in_data = v[20 + i]; #1;
         chk("t5_in_ready", 64'(in_ready), 64'd1);
      end
      @(negedge clk); in_valid = 1'b0; reset = 1'b1; #1;
      chk("t5_out_valid", 64'(out_valid),   64'd0);
      chk("t5_in_ready0", 64'(in_ready),    64'd0);
      chk("t5_set_en",    64'(dn_set_en),   64'd0);
      chk("t5_route_en",  64'(dn_route_en), 64'd0);
      chk("t5_busy",      64'(busy),        64'd0);
      chk("t5_cfg_done",  64'(cfg_done),    64'd0);
      chk("t5_cfg_ready", 64'(cfg_ready),   64'd1);
      chk("t5_route_sig", 64'(dn_route_signals), 64'd0);
      @(negedge clk); reset = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk); #1;
         chk("t5_no_out", 64'(out_valid), 64'd0);
      end

      // ---------------- end-of-run scoreboard ----------------
      chk("sb_count", 64'(got_q.size()), 64'd20);
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) chk("sb_data", got_q[i], exp_q[i]);
      chk("cfg_log_count", 64'(cfg_log.size()), 64'd11);
      for (int i = 0; i < 11 && i < cfg_log.size(); i++) chk("cfg_order", 64'(cfg_log[i]), 64'(cfgv[i]));
      chk("cfg_done_count", 64'(n_done), 64'd10);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
